// File: rtl/input_irq_controller_pkg.sv
// Shared constants for the input-exception handshake: controller state encoding
// and the exception-type numbering used by the control FSM.
package input_irq_controller_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t PENDING = 2'd1;
  localparam state_t SERVICE = 2'd2;

  localparam logic [1:0] EXTYPE_INPUT    = 2'd0;
  localparam logic [1:0] EXTYPE_OVFL     = 2'd1;
  localparam logic [1:0] EXTYPE_ACCINV   = 2'd2;
  localparam logic [1:0] EXTYPE_MISALIGN = 2'd3;

  function automatic logic rising(input logic lvl, input logic lvl_q);
    return lvl & ~lvl_q;
  endfunction

endpackage

// File: rtl/input_irq_controller_sync_fifo.sv
// Small synchronous FIFO: register storage, wrapping pointers, occupancy count.
// The head word is presented combinationally on dout.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = '0;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == CNT_ZERO);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next storage, pointer and occupancy values.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/input_irq_controller.sv
// Peripheral end of the input-exception handshake: buffers device words, requests
// service with InputRecv and pops one word per rising InputRst into InData.
module input_irq_controller #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] dev_data,
  input  logic             dev_valid,
  output logic             dev_ready,
  input  logic             InputRst,
  input  logic             RdEn,
  output logic [WIDTH-1:0] InData,
  output logic             InputRecv,
  output logic             Overrun,
  output logic [AW:0]      Count
);
  import input_irq_controller_pkg::*;

  localparam logic [AW:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic             input_rst_q, input_rst_d;
  logic             input_recv_q, input_recv_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;

  logic [WIDTH-1:0] fifo_dout;
  logic [AW:0]      fifo_count;
  logic             fifo_full, fifo_empty;
  logic             push, pop, ack_edge, rd_accept, more_data;

  assign ack_edge  = rising(InputRst, input_rst_q);
  assign push      = dev_valid & ~fifo_full;
  assign pop       = (state_q == PENDING) & ack_edge & ~fifo_empty;
  assign rd_accept = (state_q == SERVICE) & RdEn;
  // No pop happens in SERVICE, so the post-edge count is non-zero iff data is
  // already queued or a word is being pushed on this edge.
  assign more_data = (fifo_count != CNT_ZERO) | push;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (dev_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      input_rst_q  <= 1'b0;
      input_recv_q <= 1'b0;
      overrun_q    <= 1'b0;
      in_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      input_rst_q  <= input_rst_d;
      input_recv_q <= input_recv_d;
      overrun_q    <= overrun_d;
      in_data_q    <= in_data_d;
    end
  end

  // Handshake next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_count != CNT_ZERO) state_d = PENDING;
        else                        state_d = IDLE;
      end
      PENDING: begin
        if (pop) state_d = SERVICE;
        else     state_d = PENDING;
      end
      SERVICE: begin
        if (RdEn) state_d = more_data ? PENDING : IDLE;
        else      state_d = SERVICE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; an overrun on the same edge as a read wins over the clear.
  always_comb begin
    input_rst_d  = InputRst;
    input_recv_d = (state_d == PENDING);
    if (pop) in_data_d = fifo_dout;
    else     in_data_d = in_data_q;
    if (dev_valid & fifo_full) overrun_d = 1'b1;
    else if (rd_accept)        overrun_d = 1'b0;
    else                       overrun_d = overrun_q;
  end

  assign dev_ready = ~fifo_full;
  assign InData    = in_data_q;
  assign InputRecv = input_recv_q;
  assign Overrun   = overrun_q;
  assign Count     = fifo_count;

endmodule

// File: tb/tb_input_irq_controller.sv
// Directed bench for input_irq_controller with a queue-based reference model
// compared against the DUT on every falling clock edge.
module tb_input_irq_controller;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] dev_data;
  logic             dev_valid;
  logic             dev_ready;
  logic             InputRst;
  logic             RdEn;
  logic [WIDTH-1:0] InData;
  logic             InputRecv;
  logic             Overrun;
  logic [AW:0]      Count;

  int errors = 0;
  int checks = 0;

  // Reference model: queued words, whether the handler owns a word, request flag.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_data;
  bit               m_hold, m_recv, m_ov, m_prev;

  input_irq_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .dev_data  (dev_data),
    .dev_valid (dev_valid),
    .dev_ready (dev_ready),
    .InputRst  (InputRst),
    .RdEn      (RdEn),
    .InData    (InData),
    .InputRecv (InputRecv),
    .Overrun   (Overrun),
    .Count     (Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = '0;
    m_hold = 1'b0;
    m_recv = 1'b0;
    m_ov   = 1'b0;
    m_prev = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    int pre;
    bit ack, accepted, rd;
    pre      = mq.size();
    ack      = InputRst && !m_prev;
    accepted = dev_valid && (pre < DEPTH);
    rd       = RdEn && m_hold;
    m_prev   = InputRst;
    if (dev_valid && pre == DEPTH) m_ov = 1'b1;
    else if (rd)                   m_ov = 1'b0;
    if (m_recv && ack) begin
      m_data = mq.pop_front();
      m_hold = 1'b1;
      m_recv = 1'b0;
    end else if (rd) begin
      m_hold = 1'b0;
    end
    if (accepted) mq.push_back(dev_data);
    if (rd)                       m_recv = (mq.size() != 0);
    else if (!m_hold && !m_recv)  m_recv = (pre != 0);
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic ir, input logic rd);
    dev_valid = v;
    dev_data  = d;
    InputRst  = ir;
    RdEn      = rd;
    @(posedge CLK);
    model_step();
    #2;
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    check("InputRecv", {31'd0, InputRecv}, {31'd0, m_recv});
    check("InData",    {16'd0, InData},    {16'd0, m_data});
    check("Count",     {29'd0, Count},     mq.size());
    check("dev_ready", {31'd0, dev_ready}, {31'd0, (mq.size() < DEPTH)});
    check("Overrun",   {31'd0, Overrun},   {31'd0, m_ov});
  end

  initial begin
    logic [WIDTH-1:0] t2 [3];
    t2[0] = 16'h1111; t2[1] = 16'h2222; t2[2] = 16'h3333;
    Reset = 1'b1; dev_valid = 1'b0; dev_data = '0; InputRst = 1'b0; RdEn = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    #1;
    check("rst_InputRecv", {31'd0, InputRecv}, 32'd0);
    check("rst_InData",    {16'd0, InData},    32'd0);
    check("rst_Count",     {29'd0, Count},     32'd0);
    check("rst_dev_ready", {31'd0, dev_ready}, 32'd1);
    check("rst_Overrun",   {31'd0, Overrun},   32'd0);

    // 1: single word round trip
    step(1'b1, 16'h00A5, 1'b0, 1'b0);
    check("t1_count1",  {29'd0, Count},     32'd1);
    check("t1_recv_n1", {31'd0, InputRecv}, 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("t1_recv_n2", {31'd0, InputRecv}, 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("t1_indata",  {16'd0, InData},    32'h00A5);
    check("t1_recv_ack",{31'd0, InputRecv}, 32'd0);
    check("t1_count0",  {29'd0, Count},     32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("t1_idle_recv", {31'd0, InputRecv}, 32'd0);

    // 2: three words in order
    for (int i = 0; i < 3; i++) step(1'b1, t2[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("t2_indata", {16'd0, InData}, {16'd0, t2[i]});
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check("t2_recv_after_rd", {31'd0, InputRecv}, (i < 2) ? 32'd1 : 32'd0);
    end

    // 3: overflow and overrun
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      if (i == 3) begin
        check("t3_count_full", {29'd0, Count},     32'd4);
        check("t3_ready_full", {31'd0, dev_ready}, 32'd0);
        check("t3_ov_before",  {31'd0, Overrun},   32'd0);
      end
    end
    check("t3_ov_set",     {31'd0, Overrun}, 32'd1);
    check("t3_count_drop", {29'd0, Count},   32'd4);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("t3_first", {16'd0, InData}, 32'h0100);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("t3_ov_clr", {31'd0, Overrun}, 32'd0);
    for (int j = 1; j < 4; j++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("t3_drain", {16'd0, InData}, 32'h0100 + j);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
    end
    check("t3_empty", {29'd0, Count}, 32'd0);

    // 4: held InputRst pops once; spurious ack in IDLE ignored
    step(1'b1, 16'h4001, 1'b0, 1'b0);
    step(1'b1, 16'h4002, 1'b0, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("t4_one_pop", {29'd0, Count},  32'd1);
    check("t4_head",    {16'd0, InData}, 32'h4001);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("t4_repend", {31'd0, InputRecv}, 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("t4_second", {16'd0, InData}, 32'h4002);
    check("t4_count0", {29'd0, Count},  32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("t4_spur_recv",  {31'd0, InputRecv}, 32'd0);
    check("t4_spur_count", {29'd0, Count},     32'd0);
    check("t4_spur_data",  {16'd0, InData},    32'h4002);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // 5: push and pop on the same edge
    step(1'b1, 16'h5001, 1'b0, 1'b0);
    step(1'b1, 16'h5002, 1'b0, 1'b0);
    step(1'b1, 16'h5003, 1'b1, 1'b0);
    check("t5_count", {29'd0, Count},  32'd2);
    check("t5_head",  {16'd0, InData}, 32'h5001);

    // 6: reset while in SERVICE with three words queued
    step(1'b1, 16'h5004, 1'b0, 1'b0);
    check("t6_count3", {29'd0, Count}, 32'd3);
    dev_valid = 1'b0; InputRst = 1'b0; RdEn = 1'b0;
    Reset = 1'b1;
    model_reset();
    #1;
    check("t6_recv",   {31'd0, InputRecv}, 32'd0);
    check("t6_indata", {16'd0, InData},    32'd0);
    check("t6_count",  {29'd0, Count},     32'd0);
    check("t6_ready",  {31'd0, dev_ready}, 32'd1);
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("t6_post_recv", {31'd0, InputRecv}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
